// File: rtl/vc_assignment_credit.sv
// vc_assignment_credit
//   Output-port VC assignment stage. It takes the single switch-allocation
//   winner presented each cycle and assigns it a downstream VC that still has
//   at least one buffer credit. The scan is round-robin, starting at rr_ptr.
//   It also keeps a credit counter for each downstream VC.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   sa_global_vld_i               SA winner valid
//   sa_global_inport_id_oh_i      one-hot winning inport (passed through, not checked)
//   sa_global_inport_vc_id_i      input VC of the winning flit
//   vc_assignment_vld_o           assignment made this cycle (same cycle as the request)
//   vc_assignment_inport_id_oh_o  gated pass-through of the winning inport
//   vc_assignment_inport_vc_id_o  gated pass-through of the winning input VC
//   vc_assignment_vc_id_o         assigned downstream VC (0 when there is no assignment)
//   credit_rtn_vld_i/_vc_id_i     one credit returned by the downstream router
//   vc_credit_avail_o             per-VC "credit count != 0", taken from registered state
//   credit_err_o                  sticky flag for credit overflow or an illegal VC id
module vc_assignment_credit #(
    parameter int INPUT_NUM       = 4,
    parameter int VC_NUM          = 4,
    parameter int VC_DEPTH        = 4,
    parameter int VC_ID_NUM_MAX_W = 2,
    parameter int CRD_W           = $clog2(VC_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sa_global_vld_i,
    input  logic [INPUT_NUM-1:0]       sa_global_inport_id_oh_i,
    input  logic [VC_ID_NUM_MAX_W-1:0] sa_global_inport_vc_id_i,
    output logic                       vc_assignment_vld_o,
    output logic [INPUT_NUM-1:0]       vc_assignment_inport_id_oh_o,
    output logic [VC_ID_NUM_MAX_W-1:0] vc_assignment_inport_vc_id_o,
    output logic [VC_ID_NUM_MAX_W-1:0] vc_assignment_vc_id_o,
    input  logic                       credit_rtn_vld_i,
    input  logic [VC_ID_NUM_MAX_W-1:0] credit_rtn_vc_id_i,
    output logic [VC_NUM-1:0]          vc_credit_avail_o,
    output logic                       credit_err_o
);

    logic [CRD_W-1:0]           crd_q [VC_NUM];
    logic [CRD_W-1:0]           crd_d [VC_NUM];
    logic [VC_ID_NUM_MAX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                       err_q, err_d;

    logic [VC_NUM-1:0]          avail;
    logic                       sel_found;
    logic [VC_ID_NUM_MAX_W-1:0] sel_vc;
    logic                       assign_vld;
    logic                       rtn_legal;

    // Selection uses only the registered counters. A credit returned this
    // cycle becomes usable on the next cycle.
    always_comb begin
        avail     = '0;
        sel_found = 1'b0;
        sel_vc    = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            avail[v] = (crd_q[v] != '0);
        end
        for (int i = 0; i < VC_NUM; i++) begin
            int idx;
            idx = (int'(rr_ptr_q) + i) % VC_NUM;
            if (!sel_found && avail[idx]) begin
                sel_found = 1'b1;
                sel_vc    = VC_ID_NUM_MAX_W'(idx);
            end
        end
    end

    assign assign_vld                   = sa_global_vld_i & sel_found;
    assign vc_assignment_vld_o          = assign_vld;
    assign vc_assignment_vc_id_o        = assign_vld ? sel_vc : '0;
    assign vc_assignment_inport_id_oh_o = assign_vld ? sa_global_inport_id_oh_i : '0;
    assign vc_assignment_inport_vc_id_o = assign_vld ? sa_global_inport_vc_id_i : '0;
    assign vc_credit_avail_o            = avail;
    assign credit_err_o                 = err_q;

    assign rtn_legal = credit_rtn_vld_i && (int'(credit_rtn_vc_id_i) < VC_NUM);

    always_comb begin
        err_d    = err_q;
        rr_ptr_d = rr_ptr_q;
        for (int v = 0; v < VC_NUM; v++) begin
            crd_d[v] = crd_q[v];
        end

        if (assign_vld) begin
            rr_ptr_d = (int'(sel_vc) == VC_NUM - 1) ? '0 : sel_vc + 1'b1;
        end

        if (credit_rtn_vld_i && !rtn_legal) begin
            err_d = 1'b1;
        end

        for (int v = 0; v < VC_NUM; v++) begin
            logic inc, dec;
            inc = rtn_legal && (int'(credit_rtn_vc_id_i) == v);
            dec = assign_vld && (int'(sel_vc) == v);
            if (inc && !dec) begin
                // A return that would exceed the buffer depth is a protocol
                // error. The counter saturates instead of wrapping.
                if (crd_q[v] == CRD_W'(VC_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    crd_d[v] = crd_q[v] + 1'b1;
                end
            end else if (dec && !inc) begin
                crd_d[v] = crd_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                crd_q[v] <= CRD_W'(VC_DEPTH);
            end
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                crd_q[v] <= crd_d[v];
            end
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/vc_assignment_credit.md
Name: vc_assignment_credit

Overview:
- Output-port VC assignment stage; consumes the single winner presented each cycle by the global switch-allocation arbiter.
- Picks a downstream VC that holds at least one credit, using round-robin among VCs with credit.
- Returns the same-cycle assignment valid that advances the global arbiter's round-robin pointer.
- Tracks per-VC downstream buffer credits: decrement on assignment, increment on credit return from the downstream router.

Parameters:
- INPUT_NUM, 4, number of router input ports; width of the one-hot inport id.
- VC_NUM, 4, number of downstream VCs on this output port.
- VC_DEPTH, 4, downstream buffer slots per VC; reset credit value.
- VC_ID_NUM_MAX_W, 2, VC id width; must be >= $clog2(VC_NUM).
- CRD_W, $clog2(VC_DEPTH+1), per-VC credit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sa_global_vld_i  in  1  global SA winner valid
- sa_global_inport_id_oh_i  in  INPUT_NUM  one-hot winning input port
- sa_global_inport_vc_id_i  in  VC_ID_NUM_MAX_W  input VC of the winning flit
- vc_assignment_vld_o  out  1  assignment made this cycle; drives the global arbiter update and crossbar enable
- vc_assignment_inport_id_oh_o  out  INPUT_NUM  pass-through of the winning inport
- vc_assignment_inport_vc_id_o  out  VC_ID_NUM_MAX_W  pass-through of the winning input VC, used for dequeue
- vc_assignment_vc_id_o  out  VC_ID_NUM_MAX_W  downstream VC assigned
- credit_rtn_vld_i  in  1  downstream returned one credit
- credit_rtn_vc_id_i  in  VC_ID_NUM_MAX_W  VC of the returned credit
- vc_credit_avail_o  out  VC_NUM  bit v = (crd[v] != 0), registered-state view
- credit_err_o  out  1  sticky error flag

Behaviour:
- State: crd[VC_NUM] (CRD_W bits each), rr_ptr (VC_ID_NUM_MAX_W bits), err (1 bit).
- Reset (rst high at posedge): crd[v]=VC_DEPTH for all v; rr_ptr=0; err=0.
- Outputs after reset: vc_credit_avail_o=all ones; credit_err_o=0. Combinational outputs are 0 whenever sa_global_vld_i=0.
- rst has priority over every same-cycle event. Any in-flight assignment or credit return during reset is discarded.
- Selection is combinational, zero latency, and uses registered crd only (no credit-return bypass):
  - avail[v] = crd[v] != 0.
  - Scan v = rr_ptr, rr_ptr+1, ... modulo VC_NUM. Pick the first v with avail[v]=1.
- vc_assignment_vld_o = sa_global_vld_i & |avail.
- When vc_assignment_vld_o=0, vc_assignment_vc_id_o=0. inport_id_oh_o and inport_vc_id_o are gated to 0 when vld_o=0.
- On a posedge with vc_assignment_vld_o=1 and selected VC s:
  - crd[s] decrements.
  - rr_ptr becomes (s+1) mod VC_NUM, wrapping from VC_NUM-1 to 0.
  - With no assignment, rr_ptr holds.
- Credit return on VC r: crd[r] increments.
  - Assignment and return on the same VC in the same cycle: net unchanged.
  - Different VCs: both update.
- Overflow: a return with crd[r]=VC_DEPTH and no same-cycle assignment on r saturates crd[r] at VC_DEPTH and sets err.
- Illegal id: credit_rtn_vc_id_i >= VC_NUM sets err and changes no counter.
- err clears only on reset.
- No credits anywhere: vld_o=0. The global arbiter is not updated, so its request persists.
- sa_global_inport_id_oh_i is not checked for one-hot; it is passed through unchanged.

Test Plan:
- Reset, then hold sa_global_vld_i=1 with inport_oh=4'b0010, vc_id=1 for 4 cycles, no returns -> vc_id_o sequence 0,1,2,3; all crd=3; vld_o=1 every cycle; inport outputs = 0010 / 1.
- Keep requesting with no returns -> after 16 grants all crd=0; vc_credit_avail_o=0000; vld_o=0 while sa_global_vld_i=1.
- From all-zero, return a credit on VC2 -> vld_o stays 0 in the return cycle; next cycle vld_o=1, vc_id_o=2, crd[2] ends at 0.
- crd[1]=1, every other crd=0, rr_ptr=1: assign VC1 and return VC1 in the same cycle -> crd[1] stays 1; rr_ptr=2; next cycle VC1 is assigned again via wrap-around.
- Fresh reset, then credit return on VC0 -> crd[0]=4 (saturated); credit_err_o=1 and stays 1 until rst.
- Assert rst mid-stream with sa_global_vld_i=1 -> next cycle all crd=4, rr_ptr=0, err=0; first grant after rst deasserts is VC0.
